// File: rtl/enc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | enc_pkg : shared constants and pointer wrap helper for prio_encoder_rr|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package enc_pkg;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  // N need not be a power of two, so the wrap is an explicit compare.
  function automatic int ptr_next(input int idx, input int n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/prio_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | prio_pick : combinational pick of highest (dir=1) or lowest set bit  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module prio_pick #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] vec,
  input  logic         dir,
  output logic [W-1:0] idx,
  output logic         any
);

  always_comb begin
    idx = '0;
    any = |vec;
    if (dir) begin
      for (int i = 0; i < N; i++) begin
        if (vec[i]) idx = W'(i);
      end
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        if (vec[i]) idx = W'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/prio_encoder_rr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | prio_encoder_rr : registered fixed/round-robin priority encoder with |
// | valid/ready output. PRIO_ENC_MULTI_FLAG_EN adds the multi port.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module prio_encoder_rr
  import enc_pkg::*;
#(
  parameter int N    = 8,
  parameter int W    = $clog2(N),
  parameter int MODE = MODE_FIXED
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] x,
  input  logic         en,
  input  logic         out_ready,
  output logic [W-1:0] y,
  output logic         valid,
  output logic         none
`ifdef PRIO_ENC_MULTI_FLAG_EN
  ,
  output logic         multi
`endif
);

  logic         w_load;
  logic         w_any;
  logic [W-1:0] w_win;

  // A held result blocks new samples unless it is being accepted this edge.
  assign w_load = en && (!valid || out_ready);

  generate
    if (MODE == MODE_RR) begin : g_rr
      logic [W-1:0] r_ptr;
      logic [N-1:0] w_masked;
      logic [W-1:0] w_idx_m;
      logic [W-1:0] w_idx_u;
      logic         w_any_m;

      assign w_masked = x & ({N{1'b1}} << r_ptr);

      prio_pick #(.N(N), .W(W)) u_pick_m (
        .vec (w_masked),
        .dir (1'b0),
        .idx (w_idx_m),
        .any (w_any_m)
      );

      prio_pick #(.N(N), .W(W)) u_pick_u (
        .vec (x),
        .dir (1'b0),
        .idx (w_idx_u),
        .any (w_any)
      );

      assign w_win = w_any_m ? w_idx_m : w_idx_u;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_ptr <= '0;
        end else if (w_load && w_any) begin
          r_ptr <= W'(ptr_next(int'(w_win), N));
        end
      end
    end else begin : g_fixed
      prio_pick #(.N(N), .W(W)) u_pick (
        .vec (x),
        .dir (1'b1),
        .idx (w_win),
        .any (w_any)
      );
    end
  endgenerate

`ifdef PRIO_ENC_MULTI_FLAG_EN
  logic w_multi;
  // Clearing the lowest set bit leaves something only if x was not one-hot.
  assign w_multi = |(x & (x - {{(N-1){1'b0}}, 1'b1}));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y     <= '0;
      valid <= 1'b0;
      none  <= 1'b0;
`ifdef PRIO_ENC_MULTI_FLAG_EN
      multi <= 1'b0;
`endif
    end else if (w_load) begin
      if (w_any) begin
        y     <= w_win;
        valid <= 1'b1;
        none  <= 1'b0;
      end else begin
        valid <= 1'b0;
        none  <= 1'b1;
      end
`ifdef PRIO_ENC_MULTI_FLAG_EN
      multi <= w_multi;
`endif
    end else if (valid && out_ready) begin
      valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_prio_encoder_rr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_prio_encoder_rr : model-checked bench for three encoder configs   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_prio_encoder_rr;

  typedef struct {
    int y;
    int valid;
    int none;
    int multi;
    int ptr;
  } mstate_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] x8 = '0;
  logic [4:0] x5 = '0;
  logic       en = 1'b0;
  logic       rdy = 1'b0;
  bit         chk_en = 1'b0;

  logic [2:0] y0, y1, y2;
  logic       v0, v1, v2;
  logic       n0, n1, n2;
  logic       mu0, mu1, mu2;

  int checks = 0;
  int errors = 0;

  mstate_t m0 = '{0, 0, 0, 0, 0};
  mstate_t m1 = '{0, 0, 0, 0, 0};
  mstate_t m2 = '{0, 0, 0, 0, 0};

  always #5 clk = ~clk;

  prio_encoder_rr #(.N(8), .MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .x(x8), .en(en), .out_ready(rdy),
    .y(y0), .valid(v0), .none(n0)
`ifdef PRIO_ENC_MULTI_FLAG_EN
    , .multi(mu0)
`endif
  );

  prio_encoder_rr #(.N(8), .MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .x(x8), .en(en), .out_ready(rdy),
    .y(y1), .valid(v1), .none(n1)
`ifdef PRIO_ENC_MULTI_FLAG_EN
    , .multi(mu1)
`endif
  );

  prio_encoder_rr #(.N(5), .MODE(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .x(x5), .en(en), .out_ready(rdy),
    .y(y2), .valid(v2), .none(n2)
`ifdef PRIO_ENC_MULTI_FLAG_EN
    , .multi(mu2)
`endif
  );

`ifndef PRIO_ENC_MULTI_FLAG_EN
  assign mu0 = 1'b0;
  assign mu1 = 1'b0;
  assign mu2 = 1'b0;
`endif

  // Reference behaviour: scan requests directly from the priority rules.
  function automatic mstate_t mstep(mstate_t s, int n, int mode,
                                    logic [7:0] xv, bit e, bit r);
    mstate_t ns = s;
    int      w = 0;
    int      cnt = 0;
    bit      found = 0;
    for (int i = 0; i < n; i++) cnt += xv[i];
    if (mode == 0) begin
      for (int i = n - 1; i >= 0; i--)
        if (!found && xv[i]) begin w = i; found = 1; end
    end else begin
      for (int k = 0; k < n; k++) begin
        int idx = (s.ptr + k) % n;
        if (!found && xv[idx]) begin w = idx; found = 1; end
      end
    end
    if (e && (s.valid == 0 || r)) begin
      if (cnt > 0) begin
        ns.y = w;
        ns.valid = 1;
        ns.none = 0;
        if (mode == 1) ns.ptr = (w + 1) % n;
      end else begin
        ns.valid = 0;
        ns.none = 1;
      end
      ns.multi = (cnt > 1) ? 1 : 0;
    end else if (s.valid == 1 && r) begin
      ns.valid = 0;
    end
    return ns;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0 = '{0, 0, 0, 0, 0};
      m1 = '{0, 0, 0, 0, 0};
      m2 = '{0, 0, 0, 0, 0};
    end else begin
      m0 = mstep(m0, 8, 0, x8, en, rdy);
      m1 = mstep(m1, 8, 1, x8, en, rdy);
      m2 = mstep(m2, 5, 1, {3'b000, x5}, en, rdy);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("d0.y", int'(y0), m0.y);
      check("d0.valid", int'(v0), m0.valid);
      check("d0.none", int'(n0), m0.none);
      check("d1.y", int'(y1), m1.y);
      check("d1.valid", int'(v1), m1.valid);
      check("d1.none", int'(n1), m1.none);
      check("d2.y", int'(y2), m2.y);
      check("d2.valid", int'(v2), m2.valid);
      check("d2.none", int'(n2), m2.none);
      check("d2.y_range", int'(y2 <= 3'd4), 1);
`ifdef PRIO_ENC_MULTI_FLAG_EN
      check("d0.multi", int'(mu0), m0.multi);
      check("d1.multi", int'(mu1), m1.multi);
      check("d2.multi", int'(mu2), m2.multi);
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int exp1[5] = '{0, 2, 7, 0, 2};
  int exp2[5] = '{0, 4, 0, 4, 0};

  initial begin
    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    #1;
    check("reset.y", int'(y0), 0);
    check("reset.valid", int'(v0), 0);
    check("reset.none", int'(n0), 0);
    repeat (2) step();
    rst_n = 1'b1;

    // Fixed priority: highest set index wins.
    en = 1'b1; rdy = 1'b1; x8 = 8'b0000_0100;
    step();
    check("fixed.y_04", int'(y0), 2);
    check("fixed.valid_04", int'(v0), 1);
    x8 = 8'b1001_0010;
    step();
    check("fixed.y_92", int'(y0), 7);
    check("fixed.valid_92", int'(v0), 1);

    // Backpressure holds the pending result regardless of x.
    x8 = 8'h08;
    step();
    check("bp.y_start", int'(y0), 3);
    rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      x8 = 8'($urandom);
      step();
      check("bp.y_hold", int'(y0), 3);
      check("bp.valid_hold", int'(v0), 1);
    end
    rdy = 1'b1; x8 = 8'h20;
    step();
    check("bp.y_release", int'(y0), 5);

    // Empty request vector.
    x8 = 8'h00;
    step();
    check("empty.valid", int'(v0), 0);
    check("empty.none", int'(n0), 1);
    check("empty.y", int'(y0), 5);
    en = 1'b0; x8 = 8'h01;
    step();
    check("noload.valid", int'(v0), 0);
    check("noload.none", int'(n0), 1);

    // Asynchronous reset mid-transfer.
    en = 1'b1; x8 = 8'h11;
    step();
    check("pre_rst.valid", int'(v0), 1);
    rst_n = 1'b0;
    #1;
    check("async_rst.y", int'(y0), 0);
    check("async_rst.valid", int'(v0), 0);
    check("async_rst.none", int'(n0), 0);
    check("async_rst.valid1", int'(v1), 0);
    step();
    rst_n = 1'b1;

    // Round-robin rotation with wrap, N=8 and N=5.
    x8 = 8'b1000_0101; x5 = 5'b10001; en = 1'b1; rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("rr8.y", int'(y1), exp1[i]);
      check("rr5.y", int'(y2), exp2[i]);
`ifdef PRIO_ENC_MULTI_FLAG_EN
      check("rr5.multi", int'(mu2), 1);
`endif
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      x8 = 8'($urandom);
      x5 = 5'($urandom);
      if ($urandom_range(0, 3) == 0) x8 = 8'(1 << $urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) x5 = 5'(1 << $urandom_range(0, 4));
      if ($urandom_range(0, 7) == 0) x8 = '0;
      if ($urandom_range(0, 7) == 0) x5 = '0;
      en  = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 2) != 0);
      if (i == 1500) begin
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
      end
      step();
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
